// File: rtl/pll_lock_supervisor.sv
// Reset/lock supervisor for the rPLL: pulses the PLL reset, waits for a stable
// synchronized lock, then releases sys_reset; re-initialises the PLL on timeout or lock loss.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PLL_RST   | pll_reset held high for RST_CYCLES cycles
// WAIT_LOCK | waiting for lock_s, bounded by LOCK_TIMEOUT
// STABLE    | lock_s must stay high for LOCK_STABLE consecutive cycles
// RUN       | locked, sys_reset released; any lock drop re-resets the PLL
module pll_lock_supervisor #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 27000,
    parameter int LOCK_STABLE  = 256,
    parameter int CNT_W        = 16
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       restart,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       locked,
    output logic       lock_lost,
    output logic [7:0] retry_cnt
);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             sync_q1;
    logic             lock_s;
    logic             retry_inc;
    logic             lost_nx;

    // pll_lock is asynchronous to clkin
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            sync_q1 <= pll_lock;
            lock_s  <= sync_q1;
        end
    end

    always_comb begin
        state_nx  = state;
        retry_inc = 1'b0;
        lost_nx   = 1'b0;
        if (restart) begin
            state_nx = PLL_RST;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == RST_LAST) state_nx = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nx = STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_nx  = PLL_RST;
                        retry_inc = 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) state_nx = WAIT_LOCK;
                    else if (cnt == STABLE_LAST) state_nx = RUN;
                end
                RUN: begin
                    if (!lock_s) begin
                        state_nx = PLL_RST;
                        lost_nx  = 1'b1;
                    end
                end
                default: state_nx = PLL_RST;
            endcase
        end
        // a restart into PLL_RST from PLL_RST must still restart the pulse
        if (restart || (state_nx != state) || (state_nx == RUN)) cnt_nx = '0;
        else cnt_nx = cnt + 1'b1;
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
            retry_cnt <= 8'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            pll_reset <= (state_nx == PLL_RST);
            sys_reset <= (state_nx != RUN);
            locked    <= (state_nx == RUN);
            lock_lost <= lost_nx;
            if (retry_inc && (retry_cnt != 8'hFF)) retry_cnt <= retry_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed lock scenarios plus random
// lock/restart/reset stimulus against a timestamp-based phase model.
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 32;
    localparam int LOCK_STABLE  = 8;

    logic       clkin    = 1'b0;
    logic       reset    = 1'b1;
    logic       restart  = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic       sys_reset;
    logic       locked;
    logic       lock_lost;
    logic [7:0] retry_cnt;

    always #5 clkin = ~clkin;

    pll_lock_supervisor #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .CNT_W       (16)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .restart  (restart),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .sys_reset(sys_reset),
        .locked   (locked),
        .lock_lost(lock_lost),
        .retry_cnt(retry_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // model: phase plus the edge number at which the phase was entered
    localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3;
    int ph = P_RST;
    int t0 = 0;
    int cyc = 0;
    bit m_s1 = 0, m_s2 = 0, m_lost = 0;
    int m_retry = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit rs, input bit lk);
        bit lks;
        int el;
        int nph;
        cyc++;
        if (r) begin
            ph = P_RST; t0 = cyc; m_s1 = 0; m_s2 = 0; m_retry = 0; m_lost = 0;
            return;
        end
        lks  = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        el   = cyc - t0;
        nph  = ph;
        m_lost = 0;
        if (rs) nph = P_RST;
        else if (ph == P_RST) begin
            if (el >= RST_CYCLES) nph = P_WAIT;
        end else if (ph == P_WAIT) begin
            if (lks) nph = P_STB;
            else if (el >= LOCK_TIMEOUT) begin
                nph = P_RST;
                if (m_retry < 255) m_retry++;
            end
        end else if (ph == P_STB) begin
            if (!lks) nph = P_WAIT;
            else if (el >= LOCK_STABLE) nph = P_RUN;
        end else begin
            if (!lks) begin nph = P_RST; m_lost = 1; end
        end
        if (rs || nph != ph) t0 = cyc;
        ph = nph;
    endtask

    task automatic tick(input bit r, input bit rs, input bit lk);
        reset = r; restart = rs; pll_lock = lk;
        @(posedge clkin);
        model_edge(r, rs, lk);
        #1;
        check("pll_reset", 32'(pll_reset), 32'(ph == P_RST));
        check("sys_reset", 32'(sys_reset), 32'(ph != P_RUN));
        check("locked",    32'(locked),    32'(ph == P_RUN));
        check("lock_lost", 32'(lock_lost), 32'(m_lost));
        check("retry_cnt", 32'(retry_cnt), 32'(m_retry));
    endtask

    // releases reset with lock high; measures pll_reset pulse and sys_reset release
    task automatic seq_release(input string tag);
        int pr_fall = 0;
        int sys_fall = 0;
        for (int i = 1; i <= 60; i++) begin
            tick(0, 0, 1);
            if (!pll_reset && pr_fall == 0) pr_fall = i;
            if (!sys_reset) begin sys_fall = i; break; end
        end
        check({tag, "_pll_rst_len"}, 32'(pr_fall), 32'(RST_CYCLES));
        check({tag, "_release"}, 32'(sys_fall), 32'(RST_CYCLES + 1 + LOCK_STABLE));
        check({tag, "_locked"}, 32'(locked), 32'd1);
    endtask

    task automatic run_until_phase(input int p, input int el_want, input bit lk);
        int i;
        for (i = 0; i < 200; i++) begin
            if (ph == p && (cyc - t0) == el_want) break;
            tick(0, 0, lk);
        end
        check("phase_reached", 32'(i < 200), 32'd1);
    endtask

    initial begin
        int n;
        bit seen_low;
        bit lk;

        // 1: constant lock
        tick(1, 0, 1); tick(1, 0, 1);
        seq_release("t1");

        // 2: no lock -> timeouts
        tick(1, 0, 0);
        n = 0; seen_low = 0;
        for (int i = 1; i <= 100; i++) begin
            tick(0, 0, 0);
            if (!pll_reset) seen_low = 1;
            if (seen_low && pll_reset) begin n = i; break; end
        end
        check("t2_timeout_at", 32'(n), 32'(RST_CYCLES + LOCK_TIMEOUT));
        check("t2_retry1", 32'(retry_cnt), 32'd1);
        for (int i = 0; i < 300 * (RST_CYCLES + LOCK_TIMEOUT); i++) tick(0, 0, 0);
        check("t2_retry_sat", 32'(retry_cnt), 32'd255);

        // 3: one-cycle glitch at stable cnt 5
        tick(1, 0, 1);
        run_until_phase(P_STB, 5, 1);
        tick(0, 0, 0);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(0, 0, 1);
            if (!sys_reset) begin n = i; break; end
        end
        check("t3_glitch_release", 32'(n), 32'(3 + LOCK_STABLE));
        check("t3_retry", 32'(retry_cnt), 32'd0);

        // 4: lock loss in RUN
        tick(1, 0, 1);
        seq_release("t4pre");
        tick(0, 0, 1); tick(0, 0, 1);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(0, 0, 0);
            if (pll_reset) begin n = i; break; end
        end
        check("t4_loss_latency", 32'(n), 32'd3);
        check("t4_lock_lost", 32'(lock_lost), 32'd1);
        check("t4_sys_reset", 32'(sys_reset), 32'd1);
        tick(0, 0, 0);
        check("t4_lock_lost_1cyc", 32'(lock_lost), 32'd0);

        // 5: restart collides with timeout; restart in RUN
        tick(1, 0, 0);
        run_until_phase(P_WAIT, LOCK_TIMEOUT - 1, 0);
        tick(0, 1, 0);
        check("t5_restart_pll_rst", 32'(pll_reset), 32'd1);
        check("t5_retry_unchanged", 32'(retry_cnt), 32'd0);
        tick(1, 0, 1);
        seq_release("t5pre");
        tick(0, 1, 1);
        check("t5_run_restart_lost", 32'(lock_lost), 32'd0);
        check("t5_run_restart_rst", 32'(pll_reset), 32'd1);
        tick(0, 0, 1);
        check("t5_run_restart_lost2", 32'(lock_lost), 32'd0);

        // 6: reset mid-STABLE and mid-RUN
        tick(1, 0, 1);
        run_until_phase(P_STB, 3, 1);
        tick(1, 0, 1);
        check("t6_stb_sys_reset", 32'(sys_reset), 32'd1);
        check("t6_stb_pll_reset", 32'(pll_reset), 32'd1);
        seq_release("t6a");
        tick(0, 0, 1); tick(0, 0, 1);
        tick(1, 0, 1);
        check("t6_run_locked", 32'(locked), 32'd0);
        check("t6_run_sys_reset", 32'(sys_reset), 32'd1);
        seq_release("t6b");

        // random stimulus
        lk = 1;
        for (int i = 0; i < 5000; i++) begin
            bit r, rs, drive;
            if ($urandom_range(0, 59) == 0) lk = ~lk;
            drive = lk ^ ($urandom_range(0, 99) == 0);
            rs = ($urandom_range(0, 149) == 0);
            r  = ($urandom_range(0, 599) == 0);
            tick(r, rs, drive);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
